// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and helpers for the SRAM access controller.
package sram_access_ctrl_pkg;

    // Controller operating modes.
    typedef enum logic [1:0] {
        StReady = 2'd0,  // serving bus requests
        StDrain = 2'd1,  // waiting for an outstanding read response before a fill
        StInit  = 2'd2   // writing the init word to every location
    } ctrl_state_e;

    // Number of byte lanes in a data word.
    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/se_sram_srw_we8_unused.sv
// Behavioural single-port SRAM with byte write enables and a registered read port.
// Read data appears the cycle after a selected read and holds until the next selected read.
module se_sram_srw_we8_unused #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    clock_enable_i,
    input  logic                    select_i,
    input  logic                    read_not_write_i,
    input  logic [ADDR_WIDTH-1:0]   address_i,
    input  logic [DATA_WIDTH/8-1:0] write_enable_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    output logic [DATA_WIDTH-1:0]   data_out_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    // Selected cycles either register read data or merge enabled write lanes.
    always_ff @(posedge clk_i) begin
        if (clock_enable_i && select_i) begin
            if (read_not_write_i) begin
                data_out_q <= mem_q[address_i];
            end else begin
                for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                    if (write_enable_i[b]) begin
                        mem_q[address_i][8*b +: 8] <= write_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    assign data_out_o = data_out_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// Valid/ready front end for a single-port byte-write SRAM, with a full-array fill engine.
module sram_access_ctrl
    import sram_access_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH    = 14,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    parameter bit                    INIT_ON_RESET = 1'b1,
    localparam int unsigned          BeWidth       = be_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    // Request stream
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_read_not_write_i,
    input  logic [ADDR_WIDTH-1:0] req_address_i,
    input  logic [BeWidth-1:0]    req_byte_enable_i,
    input  logic [DATA_WIDTH-1:0] req_write_data_i,
    // Read response stream
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    // Fill control
    input  logic                  init_start_i,
    output logic                  init_busy_o,
    // SRAM side
    output logic                  sram_clock_enable_o,
    output logic                  sram_select_o,
    output logic                  sram_read_not_write_o,
    output logic [ADDR_WIDTH-1:0] sram_address_o,
    output logic [BeWidth-1:0]    sram_write_enable_o,
    output logic [DATA_WIDTH-1:0] sram_write_data_o,
    input  logic [DATA_WIDTH-1:0] sram_data_out_i
);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                  rd_pending_q, rd_pending_d;
    // Low from reset until the first clock edge afterwards; gates every strobe so that
    // nothing reaches the SRAM while reset is asserted.
    logic                  clk_en_q;

    logic                  rsp_fire;
    logic                  req_fire;

    assign rsp_fire = rd_pending_q & rsp_ready_i;

    // State, fill counter, read-pending flag and clock enable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= INIT_ON_RESET ? StInit : StReady;
            fill_cnt_q   <= '0;
            rd_pending_q <= 1'b0;
            clk_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            rd_pending_q <= rd_pending_d;
            clk_en_q     <= 1'b1;
        end
    end

    // Next-state logic and combinational SRAM strobes.
    always_comb begin
        state_d               = state_q;
        fill_cnt_d            = fill_cnt_q;
        rd_pending_d          = rd_pending_q;
        req_ready_o           = 1'b0;
        req_fire              = 1'b0;
        sram_select_o         = 1'b0;
        sram_read_not_write_o = 1'b0;
        sram_address_o        = '0;
        sram_write_enable_o   = '0;
        sram_write_data_o     = '0;

        // A consumed response frees the pending slot; a new read below may refill it.
        if (rsp_fire) begin
            rd_pending_d = 1'b0;
        end

        unique case (state_q)
            StReady: begin
                // A stalled response blocks everything so the SRAM output register holds.
                req_ready_o           = clk_en_q & (~rd_pending_q | rsp_ready_i);
                req_fire              = req_valid_i & req_ready_o;
                sram_select_o         = req_fire;
                sram_read_not_write_o = req_read_not_write_i;
                sram_address_o        = req_address_i;
                sram_write_enable_o   = req_read_not_write_i ? '0 : req_byte_enable_i;
                sram_write_data_o     = req_write_data_i;
                if (req_fire && req_read_not_write_i) begin
                    rd_pending_d = 1'b1;
                end
                // Decide on the post-cycle pending state: a response consumed this cycle
                // needs no drain, while a read accepted alongside init_start does.
                if (init_start_i && clk_en_q) begin
                    state_d = rd_pending_d ? StDrain : StInit;
                end
            end

            StDrain: begin
                if (!rd_pending_d) begin
                    state_d = StInit;
                end
            end

            StInit: begin
                if (clk_en_q) begin
                    sram_select_o         = 1'b1;
                    sram_read_not_write_o = 1'b0;
                    sram_address_o        = fill_cnt_q;
                    sram_write_enable_o   = '1;
                    sram_write_data_o     = INIT_VALUE;
                    fill_cnt_d            = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == '1) begin
                        state_d = StReady;
                    end
                end
            end

            default: begin
                state_d = StReady;
            end
        endcase
    end

    assign rsp_valid_o         = rd_pending_q;
    assign rsp_data_o          = sram_data_out_i;
    assign init_busy_o         = (state_q != StReady);
    assign sram_clock_enable_o = clk_en_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed self-checking bench for sram_access_ctrl driving a behavioural SRAM.
module tb_sram_access_ctrl;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned BW   = DW / 8;
    localparam logic [31:0] INIT = 32'hC0DE_0000;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_read_not_write_i;
    logic [AW-1:0] req_address_i;
    logic [BW-1:0] req_byte_enable_i;
    logic [DW-1:0] req_write_data_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_data_o;
    logic          init_start_i;
    logic          init_busy_o;
    logic          sram_clock_enable_o;
    logic          sram_select_o;
    logic          sram_read_not_write_o;
    logic [AW-1:0] sram_address_o;
    logic [BW-1:0] sram_write_enable_o;
    logic [DW-1:0] sram_write_data_o;
    logic [DW-1:0] sram_data_out_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    sram_access_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .INIT_VALUE   (INIT),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_read_not_write_i (req_read_not_write_i),
        .req_address_i        (req_address_i),
        .req_byte_enable_i    (req_byte_enable_i),
        .req_write_data_i     (req_write_data_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_ready_i          (rsp_ready_i),
        .rsp_data_o           (rsp_data_o),
        .init_start_i         (init_start_i),
        .init_busy_o          (init_busy_o),
        .sram_clock_enable_o  (sram_clock_enable_o),
        .sram_select_o        (sram_select_o),
        .sram_read_not_write_o(sram_read_not_write_o),
        .sram_address_o       (sram_address_o),
        .sram_write_enable_o  (sram_write_enable_o),
        .sram_write_data_o    (sram_write_data_o),
        .sram_data_out_i      (sram_data_out_i)
    );

    se_sram_srw_we8_unused #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) u_sram (
        .clk_i           (clk_i),
        .clock_enable_i  (sram_clock_enable_o),
        .select_i        (sram_select_o),
        .read_not_write_i(sram_read_not_write_o),
        .address_i       (sram_address_o),
        .write_enable_i  (sram_write_enable_o),
        .write_data_i    (sram_write_data_o),
        .data_out_o      (sram_data_out_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Watches a fill until init_busy drops (bounded); pulses init_start at iteration poke.
    task automatic fill_monitor(input int poke, output int busy_cycles, output int writes,
                                output bit seq_ok);
        logic [AW-1:0] exp_addr;
        busy_cycles = 0;
        writes      = 0;
        seq_ok      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            init_start_i = (i == poke);
            #1;
            if (init_busy_o !== 1'b1) break;
            if (sram_clock_enable_o === 1'b1) busy_cycles++;
            if (sram_select_o === 1'b1) begin
                exp_addr = writes[AW-1:0];
                if (sram_read_not_write_o !== 1'b0 || sram_write_enable_o !== 4'hF ||
                    sram_address_o !== exp_addr || sram_write_data_o !== INIT) seq_ok = 1'b0;
                writes++;
            end
            tick();
        end
        init_start_i = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid_i          = 1'b1;
        req_read_not_write_i = 1'b0;
        req_address_i        = a;
        req_write_data_i     = d;
        req_byte_enable_i    = be;
        tick();
        req_valid_i = 1'b0;
    endtask

    // Single read with rsp_ready high; response checked in the cycle after acceptance.
    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        req_valid_i          = 1'b1;
        req_read_not_write_i = 1'b1;
        req_address_i        = a;
        #1;
        check({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        #1;
        check({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        check({tag, "_data"}, rsp_data_o, exp);
        tick();
    endtask

    initial begin
        int  busy_n;
        int  wr_n;
        bit  ok;
        int  valid_n;
        logic [31:0] exp_d;

        reset_i              = 1'b1;
        req_valid_i          = 1'b0;
        req_read_not_write_i = 1'b0;
        req_address_i        = '0;
        req_byte_enable_i    = '0;
        req_write_data_i     = '0;
        rsp_ready_i          = 1'b1;
        init_start_i         = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        check("rst_select", {31'd0, sram_select_o}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("rst_clk_en", {31'd0, sram_clock_enable_o}, 32'd0);
        check("rst_busy", {31'd0, init_busy_o}, 32'd1);

        // Fill on reset release
        reset_i = 1'b0;
        fill_monitor(-1, busy_n, wr_n, ok);
        check("fill0_busy_cycles", busy_n, 16);
        check("fill0_writes", wr_n, 16);
        check("fill0_seq", {31'd0, ok}, 32'd1);
        check("fill0_req_ready", {31'd0, req_ready_o}, 32'd1);
        rd_check("rd5_after_fill", 4'd5, INIT);

        // Byte-lane merge, and a write with no lanes enabled
        wr(4'd3, 32'hDEAD_BEEF, 4'b1111);
        wr(4'd3, 32'h0000_00AA, 4'b0001);
        req_valid_i          = 1'b1;
        req_read_not_write_i = 1'b0;
        req_address_i        = 4'd3;
        req_write_data_i     = 32'hFFFF_FFFF;
        req_byte_enable_i    = 4'b0000;
        #1;
        check("be0_select", {31'd0, sram_select_o}, 32'd1);
        check("be0_we", {28'd0, sram_write_enable_o}, 32'd0);
        tick();
        req_valid_i = 1'b0;
        rd_check("rd3_merge", 4'd3, 32'hDEAD_BEAA);

        // Back-to-back reads at full rate
        for (int i = 8; i < 16; i++) wr(i[AW-1:0], 32'h1000_0000 + i, 4'hF);
        ok      = 1'b1;
        valid_n = 0;
        for (int i = 0; i <= 8; i++) begin
            req_valid_i          = (i < 8);
            req_read_not_write_i = 1'b1;
            req_address_i        = 4'(8 + i);
            #1;
            if (i < 8 && req_ready_o !== 1'b1) ok = 1'b0;
            if (i > 0) begin
                exp_d = 32'h1000_0000 + 32'(8 + i - 1);
                if (rsp_valid_o === 1'b1) valid_n++;
                if (rsp_data_o !== exp_d) ok = 1'b0;
            end
            tick();
        end
        req_valid_i = 1'b0;
        check("b2b_data_order", {31'd0, ok}, 32'd1);
        check("b2b_valid_cycles", valid_n, 8);
        #1;
        check("b2b_idle_valid", {31'd0, rsp_valid_o}, 32'd0);

        // Response stall holds data and blocks the request path
        rsp_ready_i          = 1'b0;
        req_valid_i          = 1'b1;
        req_read_not_write_i = 1'b1;
        req_address_i        = 4'd3;
        tick();
        req_address_i = 4'd8;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hDEAD_BEAA ||
                req_ready_o !== 1'b0 || sram_select_o !== 1'b0) ok = 1'b0;
            tick();
        end
        check("stall_hold", {31'd0, ok}, 32'd1);
        rsp_ready_i = 1'b1;
        #1;
        check("release_ready", {31'd0, req_ready_o}, 32'd1);
        check("release_select", {31'd0, sram_select_o}, 32'd1);
        check("release_data", rsp_data_o, 32'hDEAD_BEAA);
        tick();
        req_valid_i = 1'b0;
        #1;
        check("overlap_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("overlap_data", rsp_data_o, 32'h1000_0008);
        tick();
        #1;
        check("overlap_done", {31'd0, rsp_valid_o}, 32'd0);

        // init_start with a stalled response: drain, then fill
        rsp_ready_i          = 1'b0;
        req_valid_i          = 1'b1;
        req_read_not_write_i = 1'b1;
        req_address_i        = 4'd3;
        tick();
        req_valid_i  = 1'b0;
        init_start_i = 1'b1;
        #1;
        check("drain_pre_busy", {31'd0, init_busy_o}, 32'd0);
        tick();
        init_start_i = 1'b0;
        #1;
        check("drain_busy", {31'd0, init_busy_o}, 32'd1);
        check("drain_req_ready", {31'd0, req_ready_o}, 32'd0);
        check("drain_select", {31'd0, sram_select_o}, 32'd0);
        check("drain_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        tick();
        rsp_ready_i = 1'b1;
        #1;
        check("drain_rsp_data", rsp_data_o, 32'hDEAD_BEAA);
        tick();
        fill_monitor(3, busy_n, wr_n, ok);
        check("fill1_busy_cycles", busy_n, 16);
        check("fill1_writes", wr_n, 16);
        check("fill1_seq", {31'd0, ok}, 32'd1);
        rd_check("rd3_after_fill", 4'd3, INIT);
        rd_check("rd12_after_fill", 4'd12, INIT);

        // Reset in the middle of a fill restarts it from address 0
        init_start_i = 1'b1;
        tick();
        init_start_i = 1'b0;
        repeat (7) tick();
        #1;
        check("midfill_addr", {28'd0, sram_address_o}, 32'd7);
        check("midfill_select", {31'd0, sram_select_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        check("midrst_select", {31'd0, sram_select_o}, 32'd0);
        check("midrst_we", {28'd0, sram_write_enable_o}, 32'd0);
        check("midrst_clk_en", {31'd0, sram_clock_enable_o}, 32'd0);
        tick();
        tick();
        reset_i = 1'b0;
        fill_monitor(-1, busy_n, wr_n, ok);
        check("fill2_busy_cycles", busy_n, 16);
        check("fill2_writes", wr_n, 16);
        check("fill2_seq", {31'd0, ok}, 32'd1);
        rd_check("rd0_after_refill", 4'd0, INIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
